// File: rtl/axi4_stream_multiple_downsizer_if.sv
// AXI4-Stream bundle shared by the wide input and narrow output of the downsizer.
// Widths are set per instance; tkeep/tstrb are one bit per tdata byte.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 8,
  parameter int TDEST_WIDTH = 8
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic                     tvalid;
  logic                     tready;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;

  modport master (
    output tdata, tkeep, tstrb, tvalid, tlast, tuser, tid, tdest,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tstrb, tvalid, tlast, tuser, tid, tdest,
    output tready
  );
endinterface

// File: rtl/axi4_stream_multiple_downsizer.sv
// Splits each wide AXI4-Stream beat into RATIO narrow slices, LSB slice first.
// Optional macro DOWNSIZER_TKEEP_TRIM_EN drops trailing all-null slices on tlast beats.

// One slice lane: drives its slice onto the output OR-bus only when selected.
module axi4_stream_multiple_downsizer_lane #(
  parameter int DW = 32
) (
  input  logic            sel_i,
  input  logic [DW-1:0]   data_i,
  input  logic [DW/8-1:0] keep_i,
  input  logic [DW/8-1:0] strb_i,
  output logic [DW-1:0]   data_o,
  output logic [DW/8-1:0] keep_o,
  output logic [DW/8-1:0] strb_o
);
  assign data_o = sel_i ? data_i : '0;
  assign keep_o = sel_i ? keep_i : '0;
  assign strb_o = sel_i ? strb_i : '0;
endmodule

module axi4_stream_multiple_downsizer #(
  parameter int SLAVE_TDATA_WIDTH  = 64,
  parameter int MASTER_TDATA_WIDTH = 32,
  parameter int USER_WIDTH         = 1,
  parameter int ID_WIDTH           = 8,
  parameter int DEST_WIDTH         = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o
);
  localparam int RATIO = SLAVE_TDATA_WIDTH / MASTER_TDATA_WIDTH;
  localparam int MK    = MASTER_TDATA_WIDTH / 8;
  localparam int SK    = SLAVE_TDATA_WIDTH / 8;
  localparam int POS_W = $clog2(RATIO);

  typedef enum logic {EMPTY, BUSY} state_e;

  state_e                         state_q, state_d;
  logic [POS_W-1:0]               out_pos_q, out_pos_d;
  logic [POS_W-1:0]               last_pos_q, last_pos_in;
  logic                           tfirst_q, tfirst_d;
  logic                           first_q;
  logic [SLAVE_TDATA_WIDTH-1:0]   data_q;
  logic [SK-1:0]                  keep_q, strb_q;
  logic                           last_q;
  logic [USER_WIDTH-1:0]          user_q;
  logic [ID_WIDTH-1:0]            id_q;
  logic [DEST_WIDTH-1:0]          dest_q;

  logic rx_hs, tx_hs, final_slice;

  logic [RATIO-1:0][MASTER_TDATA_WIDTH-1:0] lane_data;
  logic [RATIO-1:0][MK-1:0]                 lane_keep, lane_strb;
  logic [MASTER_TDATA_WIDTH-1:0]            slice_data;
  logic [MK-1:0]                            slice_keep, slice_strb;

  assign final_slice  = (out_pos_q == last_pos_q);
  assign pkt_i.tready = (state_q == EMPTY) ||
                        (state_q == BUSY && final_slice && pkt_o.tready);
  assign rx_hs        = pkt_i.tvalid && pkt_i.tready;
  assign tx_hs        = pkt_o.tvalid && pkt_o.tready;

`ifdef DOWNSIZER_TKEEP_TRIM_EN
  logic [POS_W-1:0] trim_pos;

  // Highest slice with any live byte; slice 0 when the whole beat is null.
  always_comb begin
    trim_pos = '0;
    for (int i = 0; i < RATIO; i++)
      if (|pkt_i.tkeep[i*MK +: MK]) trim_pos = POS_W'(i);
  end

  assign last_pos_in = pkt_i.tlast ? trim_pos : POS_W'(RATIO-1);
`else
  assign last_pos_in = POS_W'(RATIO-1);
`endif

  always_comb begin
    state_d   = state_q;
    out_pos_d = out_pos_q;
    tfirst_d  = tfirst_q;
    // An rx handshake while BUSY implies the final slice is leaving now.
    if (rx_hs) begin
      state_d   = BUSY;
      out_pos_d = '0;
      tfirst_d  = pkt_i.tlast;
    end else if (tx_hs) begin
      if (final_slice) begin
        state_d   = EMPTY;
        out_pos_d = '0;
      end else begin
        out_pos_d = out_pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      out_pos_q  <= '0;
      last_pos_q <= '0;
      tfirst_q   <= 1'b1;
      first_q    <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
      strb_q     <= '0;
      last_q     <= 1'b0;
      user_q     <= '0;
      id_q       <= '0;
      dest_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_pos_q <= out_pos_d;
      tfirst_q  <= tfirst_d;
      if (rx_hs) begin
        last_pos_q <= last_pos_in;
        first_q    <= tfirst_q;
        data_q     <= pkt_i.tdata;
        keep_q     <= pkt_i.tkeep;
        strb_q     <= pkt_i.tstrb;
        last_q     <= pkt_i.tlast;
        user_q     <= pkt_i.tuser;
        id_q       <= pkt_i.tid;
        dest_q     <= pkt_i.tdest;
      end
    end
  end

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    axi4_stream_multiple_downsizer_lane #(.DW(MASTER_TDATA_WIDTH)) u_lane (
      .sel_i  (out_pos_q == POS_W'(g)),
      .data_i (data_q[g*MASTER_TDATA_WIDTH +: MASTER_TDATA_WIDTH]),
      .keep_i (keep_q[g*MK +: MK]),
      .strb_i (strb_q[g*MK +: MK]),
      .data_o (lane_data[g]),
      .keep_o (lane_keep[g]),
      .strb_o (lane_strb[g])
    );
  end

  always_comb begin
    slice_data = '0;
    slice_keep = '0;
    slice_strb = '0;
    for (int i = 0; i < RATIO; i++) begin
      slice_data = slice_data | lane_data[i];
      slice_keep = slice_keep | lane_keep[i];
      slice_strb = slice_strb | lane_strb[i];
    end
  end

  assign pkt_o.tvalid = (state_q == BUSY);
  assign pkt_o.tdata  = slice_data;
  assign pkt_o.tkeep  = slice_keep;
  assign pkt_o.tstrb  = slice_strb;
  assign pkt_o.tid    = id_q;
  assign pkt_o.tdest  = dest_q;
  assign pkt_o.tlast  = (state_q == BUSY) && last_q && final_slice;
  // tuser marks only the very first slice of a packet.
  assign pkt_o.tuser  = (state_q == BUSY && first_q && out_pos_q == '0) ? user_q : '0;
endmodule

// File: tb/tb_axi4_stream_multiple_downsizer.sv
// Directed bench: cycle table for the 64->32 instance, hand sequence for 128->32 reset.
module tb_axi4_stream_multiple_downsizer;
  logic clk;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(64))  s64 ();
  axi4_stream_if #(.TDATA_WIDTH(32))  m64 ();
  axi4_stream_if #(.TDATA_WIDTH(128)) s128 ();
  axi4_stream_if #(.TDATA_WIDTH(32))  m128 ();

  axi4_stream_multiple_downsizer #(.SLAVE_TDATA_WIDTH(64), .MASTER_TDATA_WIDTH(32)) dut64 (
    .clk_i(clk), .rst_i(rst_a), .pkt_i(s64), .pkt_o(m64));
  axi4_stream_multiple_downsizer #(.SLAVE_TDATA_WIDTH(128), .MASTER_TDATA_WIDTH(32)) dut128 (
    .clk_i(clk), .rst_i(rst_b), .pkt_i(s128), .pkt_o(m128));

  typedef struct {
    logic        sv;
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl, su;
    logic [7:0]  sid;
    logic        mr;
    logic        esr, emv;
    logic [31:0] emd;
    logic [3:0]  emk;
    logic        eml, emu;
    logic [7:0]  emid;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic vec_t v(logic sv, logic [63:0] sd, logic [7:0] sk, logic sl, logic su,
                             logic [7:0] sid, logic mr, logic esr, logic emv, logic [31:0] emd,
                             logic [3:0] emk, logic eml, logic emu, logic [7:0] emid);
    vec_t r;
    r.sv = sv; r.sd = sd; r.sk = sk; r.sl = sl; r.su = su; r.sid = sid; r.mr = mr;
    r.esr = esr; r.emv = emv; r.emd = emd; r.emk = emk; r.eml = eml; r.emu = emu; r.emid = emid;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk128(input string nm, input logic sr, input logic mv, input logic [31:0] md,
                        input logic ml, input logic mu);
    chk({nm, ".s_tready"}, s128.tready, sr);
    chk({nm, ".m_tvalid"}, m128.tvalid, mv);
    if (mv) begin
      chk({nm, ".m_tdata"}, m128.tdata, md);
      chk({nm, ".m_tlast"}, m128.tlast, ml);
      chk({nm, ".m_tuser"}, m128.tuser, mu);
    end
  endtask

  localparam logic [63:0] BA  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] B0  = 64'h0000_0011_0000_0010;
  localparam logic [63:0] B1  = 64'h0000_0021_0000_0020;
  localparam logic [63:0] B2  = 64'h0000_0031_0000_0030;
  localparam logic [63:0] B3  = 64'h0000_0041_0000_0040;
  localparam logic [63:0] BC  = 64'hCCCC_DDDD_EEEE_FFFF;
  localparam logic [63:0] BD  = 64'h0BAD_F00D_1234_5678;
  localparam logic [63:0] BE  = 64'hAAAA_AAAA_5555_5555;
  localparam logic [63:0] BF  = 64'hFEDC_BA98_7654_3210;

  initial begin
    // Single 2-slice packet with tuser/tlast placement
    tbl[0]  = v(1, BA, 8'hFF, 1, 1, 8'd5, 1,  1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 0, 0, 0, 0, 1,          0, 1, 32'h3333_4444, 4'hF, 0, 1, 8'd5);
    tbl[2]  = v(0, 0, 0, 0, 0, 0, 1,          1, 1, 32'h1111_2222, 4'hF, 1, 0, 8'd5);
    // Back-to-back 4-beat packet
    tbl[3]  = v(1, B0, 8'hFF, 0, 1, 8'd7, 1,  1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = v(1, B1, 8'hFF, 0, 1, 8'd7, 1,  0, 1, 32'h10, 4'hF, 0, 1, 8'd7);
    tbl[5]  = v(1, B1, 8'hFF, 0, 1, 8'd7, 1,  1, 1, 32'h11, 4'hF, 0, 0, 8'd7);
    tbl[6]  = v(1, B2, 8'hFF, 0, 1, 8'd7, 1,  0, 1, 32'h20, 4'hF, 0, 0, 8'd7);
    tbl[7]  = v(1, B2, 8'hFF, 0, 1, 8'd7, 1,  1, 1, 32'h21, 4'hF, 0, 0, 8'd7);
    tbl[8]  = v(1, B3, 8'hFF, 1, 1, 8'd7, 1,  0, 1, 32'h30, 4'hF, 0, 0, 8'd7);
    tbl[9]  = v(1, B3, 8'hFF, 1, 1, 8'd7, 1,  1, 1, 32'h31, 4'hF, 0, 0, 8'd7);
    tbl[10] = v(0, 0, 0, 0, 0, 0, 1,          0, 1, 32'h40, 4'hF, 0, 0, 8'd7);
    tbl[11] = v(0, 0, 0, 0, 0, 0, 1,          1, 1, 32'h41, 4'hF, 1, 0, 8'd7);
    // Backpressure 1,0,0,1 with a pending beat, then stall on slice 0
    tbl[12] = v(1, BC, 8'hFF, 1, 1, 8'd9, 1,  1, 0, 0, 0, 0, 0, 0);
    tbl[13] = v(0, 0, 0, 0, 0, 0, 1,          0, 1, 32'hEEEE_FFFF, 4'hF, 0, 1, 8'd9);
    tbl[14] = v(1, BD, 8'hFF, 1, 1, 8'd3, 0,  0, 1, 32'hCCCC_DDDD, 4'hF, 1, 0, 8'd9);
    tbl[15] = v(1, BD, 8'hFF, 1, 1, 8'd3, 0,  0, 1, 32'hCCCC_DDDD, 4'hF, 1, 0, 8'd9);
    tbl[16] = v(1, BD, 8'hFF, 1, 1, 8'd3, 1,  1, 1, 32'hCCCC_DDDD, 4'hF, 1, 0, 8'd9);
    tbl[17] = v(0, 0, 0, 0, 0, 0, 0,          0, 1, 32'h1234_5678, 4'hF, 0, 1, 8'd3);
    tbl[18] = v(0, 0, 0, 0, 0, 0, 1,          0, 1, 32'h1234_5678, 4'hF, 0, 1, 8'd3);
    tbl[19] = v(0, 0, 0, 0, 0, 0, 1,          1, 1, 32'h0BAD_F00D, 4'hF, 1, 0, 8'd3);
    // Half-empty tlast beat (tkeep=0x0F), then all-null tlast beat
    tbl[20] = v(1, BE, 8'h0F, 1, 0, 8'd1, 1,  1, 0, 0, 0, 0, 0, 0);
`ifdef DOWNSIZER_TKEEP_TRIM_EN
    tbl[21] = v(0, 0, 0, 0, 0, 0, 1,          1, 1, 32'h5555_5555, 4'hF, 1, 0, 8'd1);
    tbl[22] = v(0, 0, 0, 0, 0, 0, 1,          1, 0, 0, 0, 0, 0, 0);
`else
    tbl[21] = v(0, 0, 0, 0, 0, 0, 1,          0, 1, 32'h5555_5555, 4'hF, 0, 0, 8'd1);
    tbl[22] = v(0, 0, 0, 0, 0, 0, 1,          1, 1, 32'hAAAA_AAAA, 4'h0, 1, 0, 8'd1);
`endif
    tbl[23] = v(0, 0, 0, 0, 0, 0, 1,          1, 0, 0, 0, 0, 0, 0);
    tbl[24] = v(1, BF, 8'h00, 1, 1, 8'd2, 1,  1, 0, 0, 0, 0, 0, 0);
`ifdef DOWNSIZER_TKEEP_TRIM_EN
    tbl[25] = v(0, 0, 0, 0, 0, 0, 1,          1, 1, 32'h7654_3210, 4'h0, 1, 1, 8'd2);
    tbl[26] = v(0, 0, 0, 0, 0, 0, 1,          1, 0, 0, 0, 0, 0, 0);
`else
    tbl[25] = v(0, 0, 0, 0, 0, 0, 1,          0, 1, 32'h7654_3210, 4'h0, 0, 1, 8'd2);
    tbl[26] = v(0, 0, 0, 0, 0, 0, 1,          1, 1, 32'hFEDC_BA98, 4'h0, 1, 0, 8'd2);
`endif
    tbl[27] = v(0, 0, 0, 0, 0, 0, 1,          1, 0, 0, 0, 0, 0, 0);

    rst_a = 1'b1; rst_b = 1'b1;
    s64.tvalid = 0; s64.tdata = '0; s64.tkeep = '0; s64.tstrb = '0; s64.tlast = 0;
    s64.tuser = '0; s64.tid = '0; s64.tdest = '0; m64.tready = 1'b1;
    s128.tvalid = 0; s128.tdata = '0; s128.tkeep = '0; s128.tstrb = '0; s128.tlast = 0;
    s128.tuser = '0; s128.tid = '0; s128.tdest = '0; m128.tready = 1'b1;

    tick(); tick();
    chk("rst.m_tvalid", m64.tvalid, 1'b0);
    chk("rst.m_tlast",  m64.tlast,  1'b0);
    chk("rst.m_tuser",  m64.tuser,  1'b0);
    chk("rst.m_tdata",  m64.tdata,  32'h0);
    chk("rst.m_tid",    m64.tid,    8'h0);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst.s_tready", s64.tready, 1'b1);

    for (int i = 0; i < NV; i++) begin
      s64.tvalid = tbl[i].sv;
      s64.tdata  = tbl[i].sd;
      s64.tkeep  = tbl[i].sk;
      s64.tstrb  = tbl[i].sk;
      s64.tlast  = tbl[i].sl;
      s64.tuser  = tbl[i].su;
      s64.tid    = tbl[i].sid;
      s64.tdest  = tbl[i].sid ^ 8'hFF;
      m64.tready = tbl[i].mr;
      #1;
      chk($sformatf("v%0d.s_tready", i), s64.tready, tbl[i].esr);
      chk($sformatf("v%0d.m_tvalid", i), m64.tvalid, tbl[i].emv);
      if (tbl[i].emv) begin
        chk($sformatf("v%0d.m_tdata", i), m64.tdata, tbl[i].emd);
        chk($sformatf("v%0d.m_tkeep", i), m64.tkeep, tbl[i].emk);
        chk($sformatf("v%0d.m_tstrb", i), m64.tstrb, tbl[i].emk);
        chk($sformatf("v%0d.m_tlast", i), m64.tlast, tbl[i].eml);
        chk($sformatf("v%0d.m_tuser", i), m64.tuser, tbl[i].emu);
        chk($sformatf("v%0d.m_tid", i),   m64.tid,   tbl[i].emid);
        chk($sformatf("v%0d.m_tdest", i), m64.tdest, tbl[i].emid ^ 8'hFF);
      end
      tick();
    end

    // 128->32: reset mid-beat, then the next packet restarts at slice 0 with tuser
    s128.tvalid = 1; s128.tdata = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    s128.tkeep = 16'hFFFF; s128.tstrb = 16'hFFFF; s128.tlast = 0; s128.tuser = 1'b1;
    s128.tid = 8'd6; s128.tdest = 8'd6; m128.tready = 1'b1;
    #1; chk128("r0", 1, 0, 0, 0, 0); tick();
    s128.tvalid = 0;
    #1; chk128("r1", 0, 1, 32'h1111_1111, 0, 1); tick();
    #1; chk128("r2", 0, 1, 32'h2222_2222, 0, 0); tick();
    #1; chk128("r3", 0, 1, 32'h3333_3333, 0, 0);
    rst_b = 1'b1;
    #1; chk("r3.rst.m_tvalid", m128.tvalid, 1'b0);
    tick();
    rst_b = 1'b0;
    #1; chk128("r4", 1, 0, 0, 0, 0);
    s128.tvalid = 1; s128.tdata = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
    s128.tlast = 1; s128.tuser = 1'b1; s128.tid = 8'd4;
    #1; chk128("r5", 1, 0, 0, 0, 0); tick();
    s128.tvalid = 0;
    #1; chk128("r6", 0, 1, 32'h5555_5555, 0, 1); tick();
    #1; chk128("r7", 0, 1, 32'h6666_6666, 0, 0); tick();
    #1; chk128("r8", 0, 1, 32'h7777_7777, 0, 0); tick();
    #1; chk128("r9", 1, 1, 32'h8888_8888, 1, 0); tick();
    #1; chk128("r10", 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_stream_multiple_downsizer.md
AXI4_STREAM_MULTIPLE_DOWNSIZER -- requirements
Module: axi4_stream_multiple_downsizer

Interface
REQ-001 Parameter SLAVE_TDATA_WIDTH, default 64: input tdata width in bits; integer multiple of MASTER_TDATA_WIDTH.
REQ-002 Parameter MASTER_TDATA_WIDTH, default 32: output tdata width in bits; multiple of 8.
REQ-003 Derived values: RATIO = SLAVE_TDATA_WIDTH / MASTER_TDATA_WIDTH, with RATIO >= 2; slice = MASTER_TDATA_WIDTH bits of tdata plus MASTER_TDATA_WIDTH/8 bits of tkeep/tstrb.
REQ-004 clk_i  input  1  clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 pkt_i  axi4_stream_if.slave  SLAVE_TDATA_WIDTH  wide input stream (tdata, tkeep, tstrb, tvalid, tready, tlast, tuser, tid, tdest).
REQ-007 pkt_o  axi4_stream_if.master  MASTER_TDATA_WIDTH  narrow output stream, same signal set.

Function
REQ-008 Each accepted wide beat SHALL be split into slices emitted on pkt_o, least-significant slice (bits MASTER_TDATA_WIDTH-1:0) first.
REQ-009 Beat holding register plus slice counter out_pos (0..RATIO-1); states: EMPTY (no beat held), BUSY (beat held, pkt_o.tvalid=1).
REQ-010 EMPTY -> BUSY on rx handshake; BUSY -> EMPTY on tx handshake of final slice with no simultaneous rx handshake; BUSY -> BUSY when the final slice departs and a new beat is accepted in the same cycle.
REQ-011 pkt_i.tready SHALL be combinational: 1 when EMPTY, or when BUSY and the final slice of the held beat is transferring (pkt_o.tready=1).
REQ-012 Latency: first slice valid on pkt_o the cycle after the rx handshake; sustained throughput one slice per cycle with no bubbles between beats.
REQ-013 pkt_o.tdata/tkeep/tstrb SHALL be the out_pos-indexed slice of the held beat; out_pos increments on each tx handshake and returns to 0 on the final slice.
REQ-014 pkt_o.tid and pkt_o.tdest SHALL equal the held beat's values for every slice.
REQ-015 pkt_o.tlast SHALL be 1 only on the final slice of a beat whose tlast=1; 0 on all other slices.
REQ-016 pkt_o.tuser SHALL carry the held beat's tuser only on slice 0 of the first beat of a packet (tfirst set after reset and after each tlast beat); 0 on all other slices.
REQ-017 Final slice index = RATIO-1, except as modified by REQ-022.
REQ-018 pkt_o.tvalid SHALL not drop while BUSY and pkt_o.tready=0; the presented slice and its sideband SHALL be held stable under backpressure.

Reset
REQ-019 While rst_i=1: state EMPTY, out_pos=0, tfirst=1, pkt_o.tvalid=0, pkt_o.tlast=0, pkt_o.tuser=0, held beat tdata/tkeep/tstrb/tid/tdest=0; pkt_i.tready=1 after reset release.
REQ-020 Reset asserted mid-beat SHALL discard remaining slices; no partial slice is emitted after release.

Configuration
REQ-021 Macro DOWNSIZER_TKEEP_TRIM_EN selects trailing-slice trimming.
REQ-022 With DOWNSIZER_TKEEP_TRIM_EN defined: on a beat with tlast=1, the final slice SHALL be the highest slice whose tkeep is non-zero; slices above it are not emitted; if all tkeep bits are 0, slice 0 is emitted with tkeep=0 and tlast=1.
REQ-023 Without DOWNSIZER_TKEEP_TRIM_EN: all RATIO slices are always emitted regardless of tkeep, including all-zero slices.

Verification
REQ-024 64->32, beat tdata=0x11112222_33334444, tkeep=0xFF, tlast=1, tuser=1, pkt_o.tready=1 -> out 0x33334444 (tuser=1, tlast=0), then 0x11112222 (tuser=0, tlast=1) on consecutive cycles.
REQ-025 Back-to-back 4-beat packet, pkt_o.tready=1 -> 8 slices on 8 consecutive cycles, pkt_i.tready=1 every 2nd cycle, tuser only on slice 0, tlast only on slice 7.
REQ-026 pkt_o.tready toggling 1,0,0,1 during a beat -> slice held stable while stalled, pkt_i.tready=0 until final slice departs, no data loss.
REQ-027 Macro defined, tlast beat tkeep=0x0F -> single slice emitted with tkeep=0xF, tlast=1; macro undefined -> two slices, second with tkeep=0x0, tlast=1.
REQ-028 128->32 (RATIO=4), rst_i pulsed after 2nd slice -> pkt_o.tvalid=0 immediately, next packet starts at slice 0 with tuser propagated.
REQ-029 Macro defined, tlast beat tkeep=0x00 -> single slice, tkeep=0, tlast=1.
